// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the cache word writer.
// Geometry helpers keep the byte/line/set arithmetic in one place.
package cache_pkg;

    typedef enum logic [1:0] {
        WW_IDLE,
        WW_HOLD,
        WW_WRITE
    } ww_state_e;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_NUM_WAYS      = 4;

    // Store request as presented by the core at the default geometry.
    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0]  addr;
        logic [DEF_DATA_WIDTH-1:0]     data;
        logic [DEF_DATA_WIDTH/8-1:0]   be;
        logic [$clog2(DEF_NUM_WAYS)-1:0] way;
    } ww_req_t;

    function automatic int bpw(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int line_ofs(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic int idx_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/cache_word_writer.sv
// Coalescing word-store engine: queues byte-enabled stores, merges runs
// to the same line/way into one buffer, writes it back as one masked line.
module cache_word_writer
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_WAYS      = 4,
    parameter int NUM_SETS      = 64,
    parameter int QUEUE_DEPTH   = 4,
    parameter int FLUSH_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDRESS_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]         req_data,
    input  logic [DATA_WIDTH/8-1:0]       req_be,
    input  logic [$clog2(NUM_WAYS)-1:0]   req_way,
    input  logic                          flush,
    output logic [NUM_WAYS-1:0]           way_we,
    output logic [$clog2(NUM_SETS)-1:0]   way_index,
    output logic [BLOCK_SIZE*8-1:0]       way_wdata,
    output logic [BLOCK_SIZE-1:0]         way_byte_en,
    input  logic                          way_ack,
    output logic                          busy,
    output logic                          flush_done
);

    localparam int BPW       = bpw(DATA_WIDTH);
    localparam int OFS       = line_ofs(BLOCK_SIZE);
    localparam int WOFS      = $clog2(BPW);
    localparam int WPL       = BLOCK_SIZE / BPW;
    localparam int SLOT_W    = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int LINE_W    = ADDRESS_WIDTH - OFS;
    localparam int IDX_W     = idx_bits(NUM_SETS);
    localparam int WAY_W     = $clog2(NUM_WAYS);
    localparam int LINE_BITS = BLOCK_SIZE * 8;
    localparam int CNT_W     = $clog2(FLUSH_TIMEOUT) + 1;

    // Queue entries carry the address already split into line and slot.
    typedef struct packed {
        logic [LINE_W-1:0]     line;
        logic [SLOT_W-1:0]     slot;
        logic [DATA_WIDTH-1:0] data;
        logic [BPW-1:0]        be;
        logic [WAY_W-1:0]      way;
    } req_t;

    ww_state_e             state_q, state_d;
    logic [LINE_W-1:0]     buf_line_q, buf_line_d;
    logic [WAY_W-1:0]      buf_way_q, buf_way_d;
    logic [LINE_BITS-1:0]  buf_data_q, buf_data_d;
    logic [BLOCK_SIZE-1:0] buf_mask_q, buf_mask_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  flush_pending_q, flush_pending_d;

    req_t                  in_req;
    req_t                  head;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    logic                  head_match;
    logic                  in_write;
    logic                  flush_fire;
    logic [LINE_BITS-1:0]  merged_data;
    logic [BLOCK_SIZE-1:0] merged_mask;

    assign in_req.line = req_addr[ADDRESS_WIDTH-1:OFS];
    assign in_req.slot = SLOT_W'(req_addr[OFS-1:0] >> WOFS);
    assign in_req.data = req_data;
    assign in_req.be   = req_be;
    assign in_req.way  = req_way;

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full && (|req_be);

    sync_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (in_req),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_match = !fifo_empty
                     && (head.line == buf_line_q)
                     && (head.way == buf_way_q);

    // A fresh load starts from an empty line; a merge starts from the buffer.
    always_comb begin
        merged_data = (state_q == WW_IDLE) ? '0 : buf_data_q;
        merged_mask = (state_q == WW_IDLE) ? '0 : buf_mask_q;
        for (int i = 0; i < BPW; i++) begin
            if (head.be[i]) begin
                merged_data[(int'(head.slot) * BPW + i) * 8 +: 8] =
                    head.data[i * 8 +: 8];
                merged_mask[int'(head.slot) * BPW + i] = 1'b1;
            end
        end
    end

    assign flush_fire = flush_pending_q
                     && (state_q == WW_IDLE)
                     && fifo_empty;

    always_comb begin
        state_d         = state_q;
        buf_line_d      = buf_line_q;
        buf_way_d       = buf_way_q;
        buf_data_d      = buf_data_q;
        buf_mask_d      = buf_mask_q;
        buf_valid_d     = buf_valid_q;
        cnt_d           = cnt_q;
        pop             = 1'b0;
        flush_pending_d = (flush_pending_q && !flush_fire) || flush;

        unique case (state_q)
            WW_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    buf_line_d  = head.line;
                    buf_way_d   = head.way;
                    buf_data_d  = merged_data;
                    buf_mask_d  = merged_mask;
                    buf_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = WW_HOLD;
                end
            end
            WW_HOLD: begin
                if (head_match) begin
                    pop        = 1'b1;
                    buf_data_d = merged_data;
                    buf_mask_d = merged_mask;
                    cnt_d      = '0;
                end else if (!fifo_empty || flush_pending_q
                             || (cnt_q == CNT_W'(FLUSH_TIMEOUT - 1))) begin
                    state_d = WW_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WW_WRITE: begin
                if (way_ack) begin
                    buf_valid_d = 1'b0;
                    state_d     = WW_IDLE;
                end
            end
            default: begin
                state_d = WW_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= WW_IDLE;
            buf_line_q      <= '0;
            buf_way_q       <= '0;
            buf_data_q      <= '0;
            buf_mask_q      <= '0;
            buf_valid_q     <= 1'b0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            buf_line_q      <= buf_line_d;
            buf_way_q       <= buf_way_d;
            buf_data_q      <= buf_data_d;
            buf_mask_q      <= buf_mask_d;
            buf_valid_q     <= buf_valid_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Array-side outputs come straight from registers, so reset clears them at once.
    assign in_write = (state_q == WW_WRITE);

    always_comb begin
        way_we = '0;
        if (in_write) begin
            way_we[buf_way_q] = 1'b1;
        end
    end

    assign way_index   = in_write ? buf_line_q[IDX_W-1:0] : '0;
    assign way_wdata   = in_write ? buf_data_q : '0;
    assign way_byte_en = in_write ? buf_mask_q : '0;
    assign busy        = !fifo_empty || buf_valid_q;
    assign flush_done  = flush_fire;

endmodule

// File: tb/tb_cache_word_writer.sv
// Directed bench for cache_word_writer: table of isolated stores plus
// hand-built coalesce, split, backpressure, flush, be=0 and reset sequences.
module tb_cache_word_writer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_data = '0;
    logic [3:0]   req_be = '0;
    logic [1:0]   req_way = '0;
    logic         flush = 1'b0;
    logic [3:0]   way_we;
    logic [5:0]   way_index;
    logic [255:0] way_wdata;
    logic [31:0]  way_byte_en;
    logic         way_ack = 1'b1;
    logic         busy;
    logic         flush_done;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0]   we;
        logic [5:0]   idx;
        logic [255:0] wd;
        logic [31:0]  ben;
    } rec_t;

    rec_t recq[$];

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [3:0]   be;
        logic [1:0]   way;
        logic [3:0]   we;
        logic [5:0]   idx;
        logic [31:0]  ben;
        logic [255:0] wd;
    } vec_t;

    vec_t vecs[4];

    cache_word_writer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_be      (req_be),
        .req_way     (req_way),
        .flush       (flush),
        .way_we      (way_we),
        .way_index   (way_index),
        .way_wdata   (way_wdata),
        .way_byte_en (way_byte_en),
        .way_ack     (way_ack),
        .busy        (busy),
        .flush_done  (flush_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        rec_t r;
        if (reset_n && way_ack && (way_we != 4'b0)) begin
            r.we  = way_we;
            r.idx = way_index;
            r.wd  = way_wdata;
            r.ben = way_byte_en;
            recq.push_back(r);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [1:0] w);
        req_addr  = a;
        req_data  = d;
        req_be    = be;
        req_way   = w;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while ((busy || way_we != 4'b0) && n < 200) begin
            tick();
            n++;
        end
        chk(name, 256'(busy), 256'(1'b0));
    endtask

    task automatic wait_we(input string name);
        int n = 0;
        while (way_we == 4'b0 && n < 50) begin
            tick();
            n++;
        end
        chk(name, 256'(way_we != 4'b0), 256'(1'b1));
    endtask

    initial begin
        vecs[0] = '{32'h44, 32'hDEADBEEF, 4'hF, 2'd2,
                    4'b0100, 6'd2, 32'h000000F0, 256'hDEADBEEF << 32};
        vecs[1] = '{32'h7FC, 32'h12345678, 4'h5, 2'd0,
                    4'b0001, 6'd63, 32'h50000000,
                    (256'h78 << 224) | (256'h34 << 240)};
        vecs[2] = '{32'h10000008, 32'hCAFEF00D, 4'h8, 2'd3,
                    4'b1000, 6'd0, 32'h00000800, 256'hCA << 88};
        vecs[3] = '{32'h20, 32'hA5A5A5A5, 4'hF, 2'd1,
                    4'b0010, 6'd1, 32'h0000000F, 256'hA5A5A5A5};

        #2;
        chk("rst_ready", 256'(req_ready), 256'(1'b1));
        chk("rst_we", 256'(way_we), 256'(4'b0));
        chk("rst_index", 256'(way_index), 256'(6'd0));
        chk("rst_wdata", way_wdata, 256'h0);
        chk("rst_byte_en", 256'(way_byte_en), 256'(32'h0));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_flush_done", 256'(flush_done), 256'(1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Isolated stores: strobe one cycle after the fifth edge.
        for (int v = 0; v < 4; v++) begin
            logic early;
            early = 1'b0;
            store(vecs[v].addr, vecs[v].data, vecs[v].be, vecs[v].way);
            for (int k = 1; k <= 4; k++) begin
                tick();
                early |= (way_we != 4'b0);
            end
            chk($sformatf("v%0d_early", v), 256'(early), 256'(1'b0));
            tick();
            chk($sformatf("v%0d_we", v), 256'(way_we), 256'(vecs[v].we));
            chk($sformatf("v%0d_index", v), 256'(way_index), 256'(vecs[v].idx));
            chk($sformatf("v%0d_byte_en", v), 256'(way_byte_en),
                256'(vecs[v].ben));
            chk($sformatf("v%0d_wdata", v), way_wdata, vecs[v].wd);
            tick();
            chk($sformatf("v%0d_we_off", v), 256'(way_we), 256'(4'b0));
            chk($sformatf("v%0d_busy", v), 256'(busy), 256'(1'b0));
        end

        // Coalesce three stores into one line write.
        recq.delete();
        store(32'h40, 32'h00001111, 4'h3, 2'd1);
        store(32'h40, 32'h22220000, 4'hC, 2'd1);
        store(32'h5C, 32'hAABBCCDD, 4'hF, 2'd1);
        wait_quiet("coal_drain");
        repeat (5) tick();
        chk("coal_count", 256'(recq.size()), 256'(1));
        if (recq.size() == 1) begin
            chk("coal_we", 256'(recq[0].we), 256'(4'b0010));
            chk("coal_index", 256'(recq[0].idx), 256'(6'd2));
            chk("coal_byte_en", 256'(recq[0].ben), 256'(32'hF000000F));
            chk("coal_wdata", recq[0].wd,
                (256'hAABBCCDD << 224) | 256'h22221111);
        end

        // Split lines/ways with stalled acks: strobes held, then in order.
        recq.delete();
        way_ack = 1'b0;
        store(32'h40, 32'h1, 4'hF, 2'd1);
        store(32'h80, 32'h2, 4'hF, 2'd1);
        store(32'h80, 32'h3, 4'hF, 2'd3);
        for (int k = 0; k < 3; k++) begin
            logic [3:0] we0;
            logic [5:0] ix0;
            logic       moved;
            wait_we($sformatf("split%0d_strobe", k));
            we0 = way_we;
            ix0 = way_index;
            moved = 1'b0;
            repeat (3) begin
                tick();
                moved |= (way_we != we0) || (way_index != ix0);
            end
            chk($sformatf("split%0d_stable", k), 256'(moved), 256'(1'b0));
            way_ack = 1'b1;
            tick();
            way_ack = 1'b0;
            chk($sformatf("split%0d_gap", k), 256'(way_we), 256'(4'b0));
        end
        way_ack = 1'b1;
        wait_quiet("split_drain");
        chk("split_count", 256'(recq.size()), 256'(3));
        if (recq.size() == 3) begin
            chk("split0", 256'({recq[0].we, recq[0].idx, recq[0].wd[31:0]}),
                256'({4'b0010, 6'd2, 32'h1}));
            chk("split1", 256'({recq[1].we, recq[1].idx, recq[1].wd[31:0]}),
                256'({4'b0010, 6'd4, 32'h2}));
            chk("split2", 256'({recq[2].we, recq[2].idx, recq[2].wd[31:0]}),
                256'({4'b1000, 6'd4, 32'h3}));
        end

        // Backpressure: array stalls 20 cycles while distinct lines stream in.
        begin
            int sent;
            int n;
            logic fire;
            recq.delete();
            way_ack = 1'b0;
            sent = 0;
            for (int c = 0; c < 20; c++) begin
                req_valid = (sent < 8);
                req_addr  = 32'(sent * 32);
                req_data  = 32'(sent + 1);
                req_be    = 4'hF;
                req_way   = 2'd0;
                fire = req_valid && req_ready;
                tick();
                if (fire) sent++;
            end
            chk("bp_accepts", 256'(sent), 256'(5));
            chk("bp_ready_low", 256'(req_ready), 256'(1'b0));
            chk("bp_stall_we", 256'({way_we, way_index}),
                256'({4'b0001, 6'd0}));
            way_ack = 1'b1;
            n = 0;
            while (sent < 8 && n < 100) begin
                req_valid = 1'b1;
                req_addr  = 32'(sent * 32);
                req_data  = 32'(sent + 1);
                fire = req_ready;
                tick();
                if (fire) sent++;
                n++;
            end
            req_valid = 1'b0;
            chk("bp_sent", 256'(sent), 256'(8));
            wait_quiet("bp_drain");
            chk("bp_count", 256'(recq.size()), 256'(8));
            for (int k = 0; k < 8 && k < recq.size(); k++) begin
                chk($sformatf("bp%0d", k),
                    256'({recq[k].idx, recq[k].ben, recq[k].wd[31:0]}),
                    256'({6'(k), 32'hF, 32'(k + 1)}));
            end
        end

        // Flush right after a store skips the idle timeout.
        store(32'h60, 32'h5A5A0001, 4'hF, 2'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_hold_we", 256'(way_we), 256'(4'b0));
        tick();
        chk("fl_write_we", 256'(way_we), 256'(4'b0001));
        chk("fl_write_index", 256'(way_index), 256'(6'd3));
        chk("fl_done_early", 256'(flush_done), 256'(1'b0));
        tick();
        chk("fl_done", 256'(flush_done), 256'(1'b1));
        tick();
        chk("fl_done_pulse", 256'(flush_done), 256'(1'b0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_idle_done", 256'(flush_done), 256'(1'b1));
        tick();
        chk("fl_idle_pulse", 256'(flush_done), 256'(1'b0));

        // All-zero byte enables are accepted and dropped.
        recq.delete();
        chk("be0_ready", 256'(req_ready), 256'(1'b1));
        store(32'h100, 32'hFFFFFFFF, 4'h0, 2'd0);
        chk("be0_busy", 256'(busy), 256'(1'b0));
        repeat (10) tick();
        chk("be0_nowrite", 256'(recq.size()), 256'(0));

        // Reset during a stalled write drops the strobe and the data.
        recq.delete();
        way_ack = 1'b0;
        store(32'h200, 32'h77777777, 4'hF, 2'd2);
        store(32'h400, 32'h88888888, 4'hF, 2'd2);
        wait_we("rst_wr_strobe");
        tick();
        chk("rst_wr_stall", 256'(way_we), 256'(4'b0100));
        reset_n = 1'b0;
        #1;
        chk("rst_wr_we", 256'(way_we), 256'(4'b0));
        chk("rst_wr_busy", 256'(busy), 256'(1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        way_ack = 1'b1;
        repeat (12) tick();
        chk("rst_wr_nowrite", 256'(recq.size()), 256'(0));
        chk("rst_wr_idle", 256'({busy, way_we}), 256'(5'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_word_writer.md
# cache_word_writer

Coalescing word-write engine for the set-associative cache data arrays. It accepts byte-enabled word stores and queues them in a small FIFO. Stores to the same line and way are merged into a one-line coalescing buffer, which is then written to the selected way as a single byte-masked line write. It sits between the core-side store path (hit way already resolved by tag lookup) and the per-way data array write ports.

## Interface
- DATA_WIDTH, 32, store word width in bits (multiple of 8)
- BLOCK_SIZE, 32, cache line size in bytes (power of 2, ≥ DATA_WIDTH/8)
- ADDRESS_WIDTH, 32, byte address width
- NUM_WAYS, 4, associativity
- NUM_SETS, 64, sets per way (power of 2)
- QUEUE_DEPTH, 4, input FIFO entries (≥2)
- FLUSH_TIMEOUT, 4, idle HOLD cycles before auto write-back (≥1)

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  store request valid
- req_ready  out  1  FIFO not full
- req_addr  in  ADDRESS_WIDTH  byte address
- req_data  in  DATA_WIDTH  store data
- req_be  in  DATA_WIDTH/8  byte enables
- req_way  in  $clog2(NUM_WAYS)  target way
- flush  in  1  pulse: drain FIFO and buffer
- way_we  out  NUM_WAYS  one-hot line write strobe
- way_index  out  $clog2(NUM_SETS)  set index
- way_wdata  out  BLOCK_SIZE*8  merged line data
- way_byte_en  out  BLOCK_SIZE  per-byte write mask
- way_ack  in  1  array accepted write this cycle
- busy  out  1  FIFO non-empty or buffer valid
- flush_done  out  1  one-cycle pulse: flush complete

## Operation
- Address split: BPW=DATA_WIDTH/8; OFS=$clog2(BLOCK_SIZE); word slot = addr[OFS-1:$clog2(BPW)]; line address = addr[ADDRESS_WIDTH-1:OFS]; index = line address low $clog2(NUM_SETS) bits.
- Push on valid&&ready. A request with req_be==0 is accepted and dropped (not enqueued).
- Buffer: line address, way, line data, byte mask, valid.
- Merge: for each i with be[i], line byte slot*BPW+i ← data byte i and mask bit ← 1. Later stores overwrite earlier bytes.
- FSM:
  - IDLE: buffer invalid. If FIFO non-empty: pop the head, load it into the buffer (mask = head bytes only), go to HOLD.
  - HOLD, evaluated in priority order:
    - (1) Head matches buffer line address and way: pop, merge, clear idle counter.
    - (2) Head mismatches, or flush pending, or (FIFO empty && counter==FLUSH_TIMEOUT-1): go to WRITE.
    - Otherwise increment the counter. The counter clears on HOLD entry.
  - WRITE: way_we[way]=1, with index/wdata/byte_en driven from the buffer and held stable until way_ack. On the ack cycle: buffer invalid, go to IDLE.
- Same line in a different way is a mismatch.
- flush sets flush_pending.
  - When pending && state IDLE && FIFO empty: clear pending and pulse flush_done.
  - Flush while already idle: flush_done pulses on the next cycle.
- Stores are written to the array in acceptance order, per line.

## Timing
- Reset values:
  - req_ready=1.
  - way_we=0; way_index, way_wdata, way_byte_en = 0.
  - busy=0, flush_done=0.
  - FSM=IDLE, FIFO empty, buffer invalid, flush_pending=0.
- Reset mid-WRITE: way_we drops asynchronously. Buffered and queued stores are discarded.
- req_ready = !fifo_full (combinational from the registered count). No push when full, even if a pop happens that cycle.
- Isolated store, way_ack tied high:
  - accepted at edge E0;
  - popped at E1;
  - HOLD for FLUSH_TIMEOUT cycles;
  - way_we high for exactly one cycle after edge E(1+FLUSH_TIMEOUT).
- way_ack is sampled only in WRITE and ignored elsewhere. A WRITE stall of any length blocks pops, not pushes.
- IDLE→HOLD costs one cycle after each write-back. Sustained throughput is one store merged per cycle.

## Structure
- Package cache_pkg:
  - FSM enum (WW_IDLE, WW_HOLD, WW_WRITE);
  - request struct {addr, data, be, way};
  - localparams/functions for BPW, OFS, index width.
- Sub-module sync_fifo (parametrised width/depth, registered count, full/empty) holds requests. The merge and FSM logic stay in cache_word_writer.

## Test plan
All scenarios use default parameters.
- Single store, addr 0x44, data 0xDEADBEEF, be 0xF, way 2, ack high → way_we=0100 one cycle after 5 edges; index 2; byte_en 0x000000F0; wdata bytes 4–7 = EF BE AD DE; busy then low.
- Coalesce: 0x40/be 0x3/0x00001111, 0x40/be 0xC/0x22220000, 0x5C/be 0xF/0xAABBCCDD, all way 1 → one write; byte_en 0xF000000F; word0=0x22221111, word7=0xAABBCCDD.
- Split: 0x40 way1, then 0x80 way1, then 0x80 way3 → three writes in order (index 2/way1, index 4/way1, index 4/way3); each strobe only after the previous ack.
- Backpressure: way_ack=0 for 20 cycles, stream distinct lines → req_ready falls after QUEUE_DEPTH+1 accepts; all stores written in order after ack resumes, none lost.
- Flush: one store, then flush the next cycle → WRITE without timeout wait; flush_done one cycle after IDLE with empty FIFO. Flush while idle → flush_done next cycle.
- Edges:
  - be=0 store → no array write, busy stays 0.
  - reset asserted during a WRITE stall → way_we low immediately, no write after release.
